// File: rtl/rv2t_sram_read_responder_pkg.sv
// Shared types for the fetch-side SRAM read responder.
package rv2t_sram_read_responder_pkg;

  // One-hot access phases: idle, low half-word, high half-word.
  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_LO   = 3'b010,
    S_HI   = 3'b100
  } state_t;

  // Wait counter width; caps WAIT_STATES at 7.
  localparam int WCNT_W = 3;

endpackage

// File: rtl/rv2t_req_slot.sv
// One-entry overwrite buffer holding the newest request not yet started.
module rv2t_req_slot #(
  parameter int AW = 30
) (
  input  logic          clk,
  input  logic          sync_reset,
  input  logic          write,
  input  logic [AW-1:0] wr_addr,
  input  logic          pop,
  output logic          valid,
  output logic [AW-1:0] addr
);

  // A write always wins over a pop so a request landing on the pop cycle is kept.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      valid <= 1'b0;
      addr  <= '0;
    end else if (write) begin
      valid <= 1'b1;
      addr  <= wr_addr;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rv2t_sram_read_responder.sv
// Serves 32-bit fetch reads as two half-word accesses on an async 16-bit SRAM.
module rv2t_sram_read_responder
  import rv2t_sram_read_responder_pkg::*;
#(
  parameter int PC_BITWIDTH    = 32,
  parameter int SRAM_ADDR_BITS = 20,
  parameter int WAIT_STATES    = 1
) (
  input  logic                      clk,
  input  logic                      sync_reset,
  input  logic                      read_mem_enable,
  input  logic [PC_BITWIDTH-1:0]    read_mem_addr,
  output logic                      mem_read_done,
  output logic [31:0]               mem_data,
  output logic [PC_BITWIDTH-1:0]    mem_read_addr_out,
  output logic                      addr_misaligned,
  output logic                      busy,
  output logic [SRAM_ADDR_BITS-1:0] sram_addr,
  output logic                      sram_ce_n,
  output logic                      sram_oe_n,
  output logic                      sram_we_n,
  input  logic [15:0]               sram_data_in
);

  localparam logic [WCNT_W-1:0] LAST_WAIT = WCNT_W'(WAIT_STATES);

  state_t                   state, next_state;
  logic [WCNT_W-1:0]        wcnt;
  logic                     last;
  logic [PC_BITWIDTH-1:2]   req_word, cur_addr, start_addr, slot_addr, next_word;
  logic                     slot_valid, slot_wr, slot_pop, start, slot_valid_nxt;
  logic [15:0]              lo_half;

  assign req_word       = read_mem_addr[PC_BITWIDTH-1:2];
  assign last           = (wcnt == LAST_WAIT);
  assign next_word      = start ? start_addr : cur_addr;
  assign slot_valid_nxt = slot_wr | (slot_valid & ~slot_pop);
  assign sram_we_n      = 1'b1;

  rv2t_req_slot #(.AW(PC_BITWIDTH-2)) u_slot (
    .clk        (clk),
    .sync_reset (sync_reset),
    .write      (slot_wr),
    .wr_addr    (req_word),
    .pop        (slot_pop),
    .valid      (slot_valid),
    .addr       (slot_addr)
  );

  // Next state; a word may start from idle or on the final high-half cycle,
  // with the pending slot served before a fresh request.
  always_comb begin
    next_state = state;
    start      = 1'b0;
    start_addr = req_word;
    slot_wr    = 1'b0;
    slot_pop   = 1'b0;
    case (state)
      S_IDLE, S_HI: begin
        if (state == S_IDLE || last) begin
          if (slot_valid) begin
            start      = 1'b1;
            slot_pop   = 1'b1;
            start_addr = slot_addr;
            slot_wr    = read_mem_enable;
          end else if (read_mem_enable) begin
            start = 1'b1;
          end
          next_state = start ? S_LO : S_IDLE;
        end else begin
          slot_wr = read_mem_enable;
        end
      end
      S_LO: begin
        slot_wr = read_mem_enable;
        if (last) next_state = S_HI;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // State, wait counter and the in-flight word address.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state    <= S_IDLE;
      wcnt     <= '0;
      cur_addr <= '0;
    end else begin
      state    <= next_state;
      wcnt     <= (state == S_IDLE || last) ? '0 : wcnt + 1'b1;
      if (start) cur_addr <= start_addr;
    end
  end

  // Half-word capture and the registered response toward the fetcher.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      lo_half           <= '0;
      mem_read_done     <= 1'b0;
      mem_data          <= '0;
      mem_read_addr_out <= '0;
      addr_misaligned   <= 1'b0;
      busy              <= 1'b0;
    end else begin
      if (state == S_LO && last) lo_half <= sram_data_in;
      mem_read_done   <= (state == S_HI) && last;
      if (state == S_HI && last) begin
        mem_data          <= {sram_data_in, lo_half};
        mem_read_addr_out <= {cur_addr, 2'b00};
      end
      addr_misaligned <= read_mem_enable && (read_mem_addr[1:0] != 2'b00);
      busy            <= (next_state != S_IDLE) || slot_valid_nxt;
    end
  end

  // SRAM pins are registered from the next state so they change cleanly per phase.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_addr <= '0;
    end else begin
      sram_ce_n <= (next_state == S_IDLE);
      sram_oe_n <= (next_state == S_IDLE);
      case (next_state)
        S_LO:    sram_addr <= {next_word[SRAM_ADDR_BITS:2], 1'b0};
        S_HI:    sram_addr <= {cur_addr[SRAM_ADDR_BITS:2], 1'b1};
        default: sram_addr <= sram_addr;
      endcase
    end
  end

endmodule
